// File: rtl/eth_rx_manchester.sv
// eth_rx_manchester
// 10BASE-T Manchester receive path. Oversamples the raw line and recovers bit
// timing from mid-bit transitions. It hunts for the preamble/SFD, then writes
// each received frame byte (destination MAC through FCS) into a BRAM write
// port, and checks the Ethernet CRC-32 residue when carrier is lost.
`timescale 1ns/1ps

module eth_rx_manchester #(
   parameter int OVERSAMPLE = 8,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              rx_p,
   output logic              rx_busy,
   output logic              bram_wr_en,
   output logic [ADDR_W-1:0] bram_wr_addr,
   output logic [7:0]        bram_wr_data,
   output logic              frame_done,
   output logic [ADDR_W:0]   frame_len,
   output logic              crc_ok,
   output logic              overflow
);

   // Sample-counter thresholds, measured in clk_en samples since the last mid-bit edge
   localparam int SC_ACC_I  = (3 * OVERSAMPLE) / 4;
   localparam int SC_LOSS_I = (3 * OVERSAMPLE) / 2;
   localparam int SC_W      = $clog2(SC_LOSS_I + 1);

   localparam logic [SC_W-1:0]   SC_ACC      = SC_ACC_I[SC_W-1:0];
   localparam logic [SC_W-1:0]   SC_LOSS     = SC_LOSS_I[SC_W-1:0];
   localparam logic [ADDR_W:0]   MAX_BYTES   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_MAX     = '1;
   localparam logic [31:0]       CRC_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0]       CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0]       CRC_RESIDUE = 32'hC704_DD7B;
   localparam logic [7:0]        SFD         = 8'hD5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HUNT = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Line front end
   logic              sync1_q;
   logic              sync2_q;
   logic              prev_q;
   logic              edge_seen;
   logic              accept;
   logic              loss;
   logic              line_bit;

   // Bit timing
   logic [SC_W-1:0]   sc_q;
   logic [SC_W-1:0]   sc_d;

   // Control
   state_t            state_q;
   state_t            state_d;
   logic [7:0]        hunt_q;
   logic [7:0]        hunt_d;
   logic [7:0]        hunt_shift;

   // Frame datapath
   logic [31:0]       crc_q;
   logic [31:0]       crc_d;
   logic [31:0]       crc_next;
   logic [7:0]        byte_q;
   logic [7:0]        byte_d;
   logic [7:0]        byte_shift;
   logic [2:0]        bit_cnt_q;
   logic [2:0]        bit_cnt_d;
   logic [ADDR_W:0]   byte_cnt_q;
   logic [ADDR_W:0]   byte_cnt_d;
   logic              ovf_q;
   logic              ovf_d;

   // Registered outputs
   logic              wr_en_q;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [7:0]        wr_data_q;
   logic [7:0]        wr_data_d;
   logic [ADDR_W:0]   frame_len_q;
   logic [ADDR_W:0]   frame_len_d;
   logic              crc_ok_q;
   logic              crc_ok_d;
   logic              overflow_q;
   logic              overflow_d;

   // Two-flop synchroniser; rx_p is asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= rx_p;
         sync2_q <= sync1_q;
      end
   end

   // Previous line sample, taken only on clk_en so edges are seen at the sample rate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else if (clk_en) begin
         prev_q <= sync2_q;
      end
   end

   // Edge classification: early edges are bit-boundary transitions and are ignored
   always_comb begin
      line_bit  = sync2_q;
      edge_seen = clk_en && (sync2_q != prev_q);
      accept    = edge_seen && (sc_q >= SC_ACC);
      loss      = clk_en && !accept && (sc_q == SC_LOSS);
   end

   // Sample counter: restarts on every accepted mid-bit edge, saturates at carrier-loss count
   always_comb begin
      sc_d = sc_q;
      if (clk_en) begin
         if (accept) begin
            sc_d = '0;
         end else if (sc_q != SC_LOSS) begin
            sc_d = sc_q + 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; DONE lasts exactly one clk regardless of clk_en
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_HUNT;
            end
         end
         S_HUNT: begin
            if (loss) begin
               state_d = S_IDLE;
            end else if (accept && (hunt_shift == SFD)) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (loss) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM outputs: busy while collecting frame bits, done pulse for the single DONE clk
   always_comb begin
      rx_busy    = (state_q == S_DATA);
      frame_done = (state_q == S_DONE);
   end

   // Shift and CRC step for the bit currently being accepted
   always_comb begin
      hunt_shift = {line_bit, hunt_q[7:1]};
      byte_shift = {line_bit, byte_q[7:1]};
      crc_next   = {crc_q[30:0], 1'b0} ^ ({32{line_bit ^ crc_q[31]}} & CRC_POLY);
   end

   // Frame datapath next-state: SFD search, byte assembly, CRC, BRAM write and frame results
   always_comb begin
      hunt_d      = hunt_q;
      crc_d       = crc_q;
      byte_d      = byte_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      ovf_d       = ovf_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_len_d = frame_len_q;
      crc_ok_d    = crc_ok_q;
      overflow_d  = overflow_q;

      case (state_q)
         S_IDLE: begin
            // The edge that wakes us up is not shifted; the preamble has bits to spare
            if (accept) begin
               hunt_d = '0;
            end
         end
         S_HUNT: begin
            if (accept) begin
               hunt_d = hunt_shift;
               if (hunt_shift == SFD) begin
                  crc_d      = CRC_INIT;
                  byte_d     = '0;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  ovf_d      = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               crc_d     = crc_next;
               byte_d    = byte_shift;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) begin
                  // Bytes beyond the buffer are counted but not written
                  if (byte_cnt_q < MAX_BYTES) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = byte_cnt_q[ADDR_W-1:0];
                     wr_data_d = byte_shift;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  if (byte_cnt_q != CNT_MAX) begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end else if (loss) begin
               // A trailing partial byte is dropped and spoils the CRC verdict
               frame_len_d = byte_cnt_q;
               crc_ok_d    = (crc_q == CRC_RESIDUE) && (bit_cnt_q == 3'd0) && !ovf_q;
               overflow_d  = ovf_q;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q        <= '0;
         hunt_q      <= '0;
         crc_q       <= '0;
         byte_q      <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_len_q <= '0;
         crc_ok_q    <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sc_q        <= sc_d;
         hunt_q      <= hunt_d;
         crc_q       <= crc_d;
         byte_q      <= byte_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         ovf_q       <= ovf_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_len_q <= frame_len_d;
         crc_ok_q    <= crc_ok_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bram_wr_en   = wr_en_q;
   assign bram_wr_addr = wr_addr_q;
   assign bram_wr_data = wr_data_q;
   assign frame_len    = frame_len_q;
   assign crc_ok       = crc_ok_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_eth_rx_manchester.sv
// Testbench for eth_rx_manchester: Manchester line generator with a
// write/frame scoreboard. A small buffer (ADDR_W=6) keeps the overflow case short.
`timescale 1ns/1ps

module tb_eth_rx_manchester;

   localparam int OS   = 8;
   localparam int AW   = 6;
   localparam int MAXB = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_en = 1'b1;
   logic          rx_p = 1'b0;
   logic          rx_busy;
   logic          bram_wr_en;
   logic [AW-1:0] bram_wr_addr;
   logic [7:0]    bram_wr_data;
   logic          frame_done;
   logic [AW:0]   frame_len;
   logic          crc_ok;
   logic          overflow;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   typedef struct packed {
      logic [AW:0] len;
      logic        ok;
      logic        ovf;
   } fr_t;

   wr_t        exp_wr[$];
   fr_t        exp_fr[$];
   logic [7:0] frm[$];

   int tests = 0;
   int fails = 0;
   int n_wr = 0;
   int n_done = 0;
   int prev_h2 = OS / 2;
   int bit_no = 0;
   bit jit = 1'b0;
   bit frz = 1'b0;
   int wr0;
   int d0;

   always #5 clk = ~clk;

   eth_rx_manchester #(
      .OVERSAMPLE (OS),
      .ADDR_W     (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_en       (clk_en),
      .rx_p         (rx_p),
      .rx_busy      (rx_busy),
      .bram_wr_en   (bram_wr_en),
      .bram_wr_addr (bram_wr_addr),
      .bram_wr_data (bram_wr_data),
      .frame_done   (frame_done),
      .frame_len    (frame_len),
      .crc_ok       (crc_ok),
      .overflow     (overflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clocks; inputs change 1 ns after the edge
   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One Manchester bit: ~b in the first half, b in the second (rising mid edge = 1).
   // With jitter each half is OS/2 +/-1 samples, keeping mid edges at least
   // 3*OS/4+1 samples apart so they remain distinguishable from boundary edges.
   task automatic send_bit(input logic b);
      int h1;
      int h2;
      h1 = OS / 2;
      h2 = OS / 2;
      if (jit) begin
         h1 = OS / 2 - 1 + int'($urandom_range(0, 2));
         if (prev_h2 + h1 < OS - 1) h1 = OS - 1 - prev_h2;
         h2 = OS / 2 - 1 + int'($urandom_range(0, 2));
      end
      rx_p = ~b;
      if (frz && (bit_no % 5 == 0)) begin
         hold(3);
         clk_en = 1'b0;
         hold(3);
         clk_en = 1'b1;
         hold(h1 - 3);
      end else begin
         hold(h1);
      end
      rx_p = b;
      hold(h2);
      prev_h2 = h2;
      bit_no++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 8; k++) send_bit(b[k]);
   endtask

   // SOI: line high for two bit times, then back to idle low
   task automatic send_soi();
      rx_p = 1'b1;
      hold(2 * OS);
      rx_p = 1'b0;
      hold(6 * OS);
   endtask

   // Standard reflected CRC-32 over frm; FCS goes out low byte first
   function automatic logic [31:0] crc32_std();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (frm[i]) begin
         c = c ^ {24'h0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build(input int n, input bit seq);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(seq ? i[7:0] : 8'($urandom_range(0, 255)));
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = crc32_std();
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
   endtask

   task automatic expect_frame(input bit fcs_good);
      fr_t f;
      f.len = (AW + 1)'(frm.size());
      f.ovf = (frm.size() > MAXB);
      f.ok  = fcs_good && !f.ovf;
      exp_fr.push_back(f);
   endtask

   // Preamble, SFD, frm bytes, optional extra bits, SOI. abort_at >= 0 pulses reset
   // just after that many bytes and leaves the line idle.
   task automatic send_frame(input bit jitter, input bit freeze, input int extra_bits, input int abort_at);
      wr_t w;
      jit = jitter;
      frz = freeze;
      prev_h2 = OS / 2;
      bit_no = 0;
      repeat (7) send_byte(8'h55);
      send_byte(8'hD5);
      for (int i = 0; i < frm.size(); i++) begin
         if (i == abort_at) begin
            rx_p = 1'b0;
            rst_n = 1'b0;
            hold(3);
            chk("abort_rst_busy", rx_busy, 0);
            chk("abort_rst_len", frame_len, 0);
            chk("abort_rst_crc_ok", crc_ok, 0);
            chk("abort_rst_overflow", overflow, 0);
            rst_n = 1'b1;
            hold(6 * OS);
            jit = 1'b0;
            frz = 1'b0;
            return;
         end
         if (i < MAXB) begin
            w.addr = i[AW-1:0];
            w.data = frm[i];
            exp_wr.push_back(w);
         end
         send_byte(frm[i]);
         if (i == 10) chk("busy_mid_frame", rx_busy, 1);
      end
      for (int k = 0; k < extra_bits; k++) send_bit(1'($urandom_range(0, 1)));
      send_soi();
      jit = 1'b0;
      frz = 1'b0;
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_writes_drained"}, exp_wr.size(), 0);
      chk({tag, "_frames_drained"}, exp_fr.size(), 0);
   endtask

   initial begin
      wr_t w;
      fr_t f;

      // Scoreboard: compare every write and frame_done against the expected queues
      fork
         forever begin
            @(negedge clk);
            if (bram_wr_en) begin
               n_wr++;
               chk("write_was_expected", exp_wr.size() != 0, 1);
               if (exp_wr.size() != 0) begin
                  w = exp_wr.pop_front();
                  $display("[TB] write addr=%0d data=%02h (exp %0d/%02h)", bram_wr_addr, bram_wr_data, w.addr, w.data);
                  chk("wr_addr", bram_wr_addr, w.addr);
                  chk("wr_data", bram_wr_data, w.data);
               end
            end
            if (frame_done) begin
               n_done++;
               chk("frame_done_was_expected", exp_fr.size() != 0, 1);
               if (exp_fr.size() != 0) begin
                  f = exp_fr.pop_front();
                  $display("[TB] frame_done len=%0d crc_ok=%0b overflow=%0b (exp %0d/%0b/%0b)", frame_len, crc_ok, overflow, f.len, f.ok, f.ovf);
                  chk("frame_len", frame_len, f.len);
                  chk("crc_ok", crc_ok, f.ok);
                  chk("overflow", overflow, f.ovf);
                  chk("busy_low_at_done", rx_busy, 0);
               end
            end
         end
      join_none

      // Reset state
      rst_n = 1'b0;
      rx_p = 1'b0;
      clk_en = 1'b1;
      hold(5);
      chk("rst_busy", rx_busy, 0);
      chk("rst_wr_en", bram_wr_en, 0);
      chk("rst_wr_addr", bram_wr_addr, 0);
      chk("rst_wr_data", bram_wr_data, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_len", frame_len, 0);
      chk("rst_crc_ok", crc_ok, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      hold(2000);
      chk("idle_no_write", n_wr, 0);
      chk("idle_no_done", n_done, 0);

      // Good 64-byte frame: exactly fills the buffer, no overflow
      build(60, 1'b1);
      add_fcs();
      expect_frame(1'b1);
      send_frame(1'b0, 1'b0, 0, -1);
      check_drained("good64");

      // Same frame with one payload bit flipped, clk_en paused every fifth bit
      build(60, 1'b1);
      add_fcs();
      frm[30] = frm[30] ^ 8'h10;
      expect_frame(1'b0);
      send_frame(1'b0, 1'b1, 0, -1);
      check_drained("flip");

      // Lone link pulse, then preamble without SFD: nothing written, no frame end
      wr0 = n_wr;
      d0 = n_done;
      rx_p = 1'b1;
      hold(OS);
      rx_p = 1'b0;
      hold(6 * OS);
      prev_h2 = OS / 2;
      repeat (7) send_byte(8'h55);
      send_soi();
      chk("pulse_no_write", n_wr, wr0);
      chk("pulse_no_done", n_done, d0);

      // 70-byte frame with valid FCS overruns the 64-byte buffer
      build(66, 1'b0);
      add_fcs();
      expect_frame(1'b1);
      send_frame(1'b0, 1'b0, 0, -1);
      check_drained("overflow");
      chk("overflow_held", overflow, 1);

      // Jittered frame with 4 extra bits before SOI: bytes intact, CRC verdict bad
      build(24, 1'b0);
      add_fcs();
      expect_frame(1'b0);
      send_frame(1'b1, 1'b0, 4, -1);
      check_drained("jitter");

      // Reset mid-frame: no frame_done for the aborted frame
      d0 = n_done;
      build(36, 1'b0);
      add_fcs();
      send_frame(1'b0, 1'b0, 0, 20);
      chk("abort_no_done", n_done, d0);
      check_drained("abort");

      // Next good frame after the abort
      build(28, 1'b0);
      add_fcs();
      expect_frame(1'b1);
      send_frame(1'b0, 1'b0, 0, -1);
      check_drained("final");
      hold(100);
      chk("len_held", frame_len, 32);
      chk("crc_ok_held", crc_ok, 1);
      chk("overflow_held_low", overflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
